// File: rtl/ct_read_arbiter.sv
// Round-robin read arbiter sharing one synchronous-read ciphertext memory among NREQ crack engines.
// Returned data is steered back with a one-hot rvalid carried by a tag pipeline matching the memory latency.
module ct_read_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rddata,
  output logic              idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [PW-1:0] LAST_REQ    = PW'(NREQ - 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST - 1);

  logic [AW-1:0]   addr_arr [NREQ];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   next_ptr;
  logic            found;
  logic [BW-1:0]   burst_cnt;
  logic [AW-1:0]   last_addr;
  logic [NREQ-1:0] tag_pipe [RD_LAT];
  logic            pipe_busy;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  // Scan from the priority pointer, wrapping, and pick the first requester.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) begin
      gnt[gidx] = 1'b1;
    end
  end

  assign next_ptr = (gidx == LAST_REQ) ? '0 : gidx + PW'(1);

  // Memory address stays parked on the last issued one while nobody is granted.
  assign mem_addr = found ? addr_arr[gidx] : last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      burst_cnt <= '0;
      last_addr <= '0;
    end else if (found) begin
      last_addr <= addr_arr[gidx];
      if (lock[gidx] && (burst_cnt < BURST_LIMIT)) begin
        ptr       <= gidx;
        burst_cnt <= burst_cnt + BW'(1);
      end else begin
        ptr       <= next_ptr;
        burst_cnt <= '0;
      end
    end
  end

  // One stage per cycle of memory latency, so the tag lines up with mem_rddata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= gnt;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < RD_LAT; s++) begin
      pipe_busy = pipe_busy | (|tag_pipe[s]);
    end
  end

  assign rvalid = tag_pipe[RD_LAT-1];
  assign rdata  = mem_rddata;
  assign idle   = ~(|gnt) & ~pipe_busy;

endmodule

// File: tb/tb_ct_read_arbiter.sv
// Bench for ct_read_arbiter: two instances (read latency 1 and 2) share stimulus and are
// compared every cycle against a queue-based arbitration model, plus directed literal checks.
module tb_ct_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  a_arr [4];
  logic [31:0] addr;
  logic [3:0]  gnt1, rvalid1, gnt2, rvalid2;
  logic [7:0]  rdata1, rdata2, mem_addr1, mem_addr2, mem_rddata1, mem_rddata2;
  logic        idle1, idle2;
  logic [7:0]  mem [256];
  logic [7:0]  q1, q2a, q2b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign addr = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

  ct_read_arbiter #(.NREQ(4), .AW(8), .DW(8), .RD_LAT(1), .MAX_BURST(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .mem_addr(mem_addr1),
    .mem_rddata(mem_rddata1), .idle(idle1)
  );

  ct_read_arbiter #(.NREQ(4), .AW(8), .DW(8), .RD_LAT(2), .MAX_BURST(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .mem_addr(mem_addr2),
    .mem_rddata(mem_rddata2), .idle(idle2)
  );

  // Synchronous-read memories with latency 1 and 2
  always @(posedge clk) begin
    q1  <= mem[mem_addr1];
    q2a <= mem[mem_addr2];
    q2b <= q2a;
  end
  assign mem_rddata1 = q1;
  assign mem_rddata2 = q2b;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: priority pointer, burst count, last address, grant/address history
  int         mptr;
  int         mburst;
  logic [7:0] mlast;
  logic [3:0] hg [$];
  logic [7:0] ha [$];

  always @(negedge clk) begin
    logic [3:0] eg;
    logic [7:0] ea;
    logic [3:0] ev1, ev2, h0, h1;
    logic [7:0] ed1, ed2;
    int g;
    if (!rst_n) begin
      mptr = 0;
      mburst = 0;
      mlast = 8'h00;
      hg.delete();
      ha.delete();
    end
    eg = 4'b0000;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && req[2'((mptr + k) % 4)]) g = (mptr + k) % 4;
    end
    if (g >= 0) eg[2'(g)] = 1'b1;
    ea = (g >= 0) ? a_arr[2'(g)] : mlast;
    h0  = (hg.size() >= 1) ? hg[0] : 4'b0000;
    h1  = (hg.size() >= 2) ? hg[1] : 4'b0000;
    ed1 = (ha.size() >= 1) ? mem[ha[0]] : 8'h00;
    ed2 = (ha.size() >= 2) ? mem[ha[1]] : 8'h00;
    ev1 = h0;
    ev2 = h1;

    checkOutput("m_gnt1", 32'(gnt1), 32'(eg));
    checkOutput("m_gnt2", 32'(gnt2), 32'(eg));
    checkOutput("m_maddr1", 32'(mem_addr1), 32'(ea));
    checkOutput("m_maddr2", 32'(mem_addr2), 32'(ea));
    checkOutput("m_rvalid1", 32'(rvalid1), 32'(ev1));
    checkOutput("m_rvalid2", 32'(rvalid2), 32'(ev2));
    checkOutput("m_idle1", 32'(idle1), 32'(eg == 4'b0000 && h0 == 4'b0000));
    checkOutput("m_idle2", 32'(idle2), 32'(eg == 4'b0000 && h0 == 4'b0000 && h1 == 4'b0000));
    if (ev1 != 4'b0000) checkOutput("m_rdata1", 32'(rdata1), 32'(ed1));
    if (ev2 != 4'b0000) checkOutput("m_rdata2", 32'(rdata2), 32'(ed2));

    if (rst_n) begin
      if (g >= 0) begin
        mlast = ea;
        if (lock[2'(g)] && mburst < 3) begin
          mptr = g;
          mburst++;
        end else begin
          mptr = (g + 1) % 4;
          mburst = 0;
        end
      end
      hg.push_front(eg);
      ha.push_front(ea);
      if (hg.size() > 2) void'(hg.pop_back());
      if (ha.size() > 2) void'(ha.pop_back());
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] a3);
    @(posedge clk);
    #1;
    req = r;
    lock = l;
    a_arr[0] = a0;
    a_arr[1] = a1;
    a_arr[2] = a2;
    a_arr[3] = a3;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = 4'b0000;
    lock = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] t2exp [5];
  logic [3:0] t3exp [6];
  logic [3:0] t4exp [3];

  initial begin
    t2exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t3exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    t4exp = '{4'b1000, 4'b0001, 4'b1000};
    for (int i = 0; i < 256; i++) mem[i] = 8'((i ^ 8'h3C) + 1);
    mem[5] = 8'hA7;
    rst_n = 1'b0;
    req = 4'b0000;
    lock = 4'b0000;
    for (int i = 0; i < 4; i++) a_arr[i] = 8'h00;

    // Reset state
    sampleCycle();
    checkOutput("rst_idle", 32'(idle1), 32'd1);
    checkOutput("rst_rvalid", 32'(rvalid1), 32'd0);
    checkOutput("rst_gnt", 32'(gnt1), 32'd0);
    checkOutput("rst_maddr", 32'(mem_addr1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1 single request
    applyStimulus(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h05, 8'h00);
    sampleCycle();
    checkOutput("t1_gnt", 32'(gnt1), 32'h4);
    checkOutput("t1_maddr", 32'(mem_addr1), 32'h05);
    applyStimulus(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t1_rvalid", 32'(rvalid1), 32'h4);
    checkOutput("t1_rdata", 32'(rdata1), 32'hA7);
    checkOutput("t1_maddr_hold", 32'(mem_addr1), 32'h05);
    checkOutput("t1_idle_busy", 32'(idle1), 32'd0);

    // T2 round robin from reset
    doReset();
    applyStimulus(4'b1111, 4'b0000, 8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 5; i++) begin
      sampleCycle();
      checkOutput($sformatf("t2_gnt%0d", i), 32'(gnt1), 32'(t2exp[i]));
    end
    applyStimulus(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t2_rdata_last", 32'(rdata1), 32'h2D);

    // T3 locked burst from requester 0
    doReset();
    applyStimulus(4'b0011, 4'b0001, 8'h20, 8'h21, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      sampleCycle();
      checkOutput($sformatf("t3_gnt%0d", i), 32'(gnt1), 32'(t3exp[i]));
    end

    // T4 pointer wrap 3 -> 0 -> 1
    doReset();
    applyStimulus(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h07, 8'h00);
    sampleCycle();
    checkOutput("t4_pre", 32'(gnt1), 32'h4);
    applyStimulus(4'b1001, 4'b0000, 8'h40, 8'h00, 8'h00, 8'h43);
    for (int i = 0; i < 3; i++) begin
      sampleCycle();
      checkOutput($sformatf("t4_gnt%0d", i), 32'(gnt1), 32'(t4exp[i]));
    end

    // T5 latency 2, back-to-back grants
    doReset();
    applyStimulus(4'b0001, 4'b0000, 8'h20, 8'h00, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t5_idle_t0", 32'(idle2), 32'd0);
    applyStimulus(4'b0010, 4'b0000, 8'h20, 8'h21, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t5_gnt_t1", 32'(gnt2), 32'h2);
    checkOutput("t5_idle_t1", 32'(idle2), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t5_rvalid_t2", 32'(rvalid2), 32'h1);
    checkOutput("t5_rdata_t2", 32'(rdata2), 32'h1D);
    checkOutput("t5_idle_t2", 32'(idle2), 32'd0);
    sampleCycle();
    checkOutput("t5_rvalid_t3", 32'(rvalid2), 32'h2);
    checkOutput("t5_rdata_t3", 32'(rdata2), 32'h1E);
    checkOutput("t5_idle_t3", 32'(idle2), 32'd0);
    sampleCycle();
    checkOutput("t5_idle_t4", 32'(idle2), 32'd1);

    // T6 reset while a read is in flight
    doReset();
    applyStimulus(4'b0010, 4'b0000, 8'h00, 8'h30, 8'h00, 8'h00);
    sampleCycle();
    checkOutput("t6_gnt", 32'(gnt1), 32'h2);
    #2;
    rst_n = 1'b0;
    req = 4'b0000;
    sampleCycle();
    checkOutput("t6_rvalid1", 32'(rvalid1), 32'd0);
    checkOutput("t6_rvalid2", 32'(rvalid2), 32'd0);
    checkOutput("t6_idle1", 32'(idle1), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sampleCycle();
    checkOutput("t6_idle_after", 32'(idle1), 32'd1);
    checkOutput("t6_rvalid2_after", 32'(rvalid2), 32'd0);
    applyStimulus(4'b1111, 4'b0000, 8'h50, 8'h51, 8'h52, 8'h53);
    sampleCycle();
    checkOutput("t6_ptr0", 32'(gnt1), 32'h1);

    applyStimulus(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) sampleCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
